key_director: RTL and testbench
===============================

# key_director

Keyboard-side front end for the ball motion logic: converts the six raw USB HID keycode slots into the single 8-bit `keycode` that the ball controller consumes once per frame. Tracks the four direction keys (A=8'h04, D=8'h07, S=8'h16, W=8'h1A), debounces each across frames, and drives the most recently pressed key that is still held (last-press priority). Sits between the USB host/PIO keycode registers and the ball controller, clocked by the vertical-sync frame clock.

## Interface
- DEB_FRAMES, 2, consecutive frames a key's raw state must differ from its debounced state before the debounced state flips; legal range 1..7.
- frame_clk  in  1  frame clock; all state updates on its rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- keys_in  in  48  six HID keycode slots; slot n = keys_in[8n+7:8n]; 8'h00 = empty slot.
- keycode  out  8  active direction keycode to ball controller; 8'h00 when no direction key is held.
- dir_valid  out  1  high when keycode is non-zero.
- dir_change  out  1  one-cycle pulse on the edge at which keycode takes a new value.

## Operation
- Key index: A=0, D=1, S=2, W=3. All other codes are ignored.
- raw_i (combinational): high if any slot of keys_in equals key i's code. A key present in several slots counts once.
- Rollover: if any slot equals 8'h01 (ErrorRollOver), the frame is a freeze frame: every raw_i is treated as equal to db_i, so all debounce counters clear and no state changes.
- Debounce per key: 3-bit cnt_i, debounced bit db_i.
  - raw_i == db_i: cnt_i <= 0.
  - raw_i != db_i and cnt_i == DEB_FRAMES-1: db_i <= raw_i, cnt_i <= 0.
  - else cnt_i <= cnt_i + 1.
- Press-order stack: 4 entries of 2-bit key index plus a 3-bit depth (0..4); entry depth-1 is the top.
  - Each edge, compare db against its value from the previous edge (rise/fall events).
  - Releases first: every key that fell is removed and the entries above it shift down, order preserved. Multiple simultaneous releases are all handled in one edge.
  - Then presses: every key that rose is pushed in index order A, D, S, W. Of several simultaneous presses, the highest index ends on top.
  - No duplicates are possible; depth never exceeds 4.
- keycode register <= code of top entry if depth > 0, else 8'h00. It is computed from the post-update stack on the same edge.
- dir_valid = (keycode != 0). It is registered alongside keycode.
- dir_change <= 1 on an edge where the new keycode differs from the old one; else 0.

## Timing
- Reset values: all cnt_i = 0, all db_i = 0, depth = 0, stack entries = 0, keycode = 8'h00, dir_valid = 0, dir_change = 0, previous-db register = 0.
- Press latency:
  - Key first present at sampling edge k and held continuously: db_i rises at edge k+DEB_FRAMES-1.
  - keycode, dir_valid and dir_change update at edge k+DEB_FRAMES.
  - With DEB_FRAMES=1, keycode updates one edge after the first sample.
- Release latency is symmetric: the first absent edge is r, and keycode updates at edge r+DEB_FRAMES.
- A raw glitch shorter than DEB_FRAMES frames resets the counter and causes no output change.
- Freeze frames do not advance counters. A key must then accumulate DEB_FRAMES consecutive non-freeze differing frames.
- Reset asserted mid-operation clears all state immediately. A key held through reset must re-debounce from zero after release.
- keycode is stable for the whole frame period. The ball controller samples it on the next frame_clk edge.

## Test plan
- Reset: assert Reset with A in keys_in -> keycode=8'h00, dir_valid=0, dir_change=0. Deassert with A held (DEB_FRAMES=2) -> keycode=8'h04 exactly 2 edges later, with dir_change high for that single cycle.
- Glitch: DEB_FRAMES=2, keys_in slot2=8'h1A for 1 frame, then 8'h00 -> keycode stays 8'h00 and dir_change never pulses.
- Priority: hold A until keycode=04, then add D in slot1 -> keycode=8'h07. Release D -> keycode returns to 8'h04 two edges after D leaves. Release A -> keycode=8'h00, dir_valid=0.
- Simultaneous: A and W appear in the same frame -> keycode=8'h1A. Release W only -> 8'h04. Release A and D together from stack {A,D} -> 8'h00 in one update.
- Rollover: A held (keycode=04), then slot5=8'h01 for 5 frames while A is removed -> keycode stays 8'h04. After rollover clears with A absent -> 8'h00 after DEB_FRAMES edges.
- Reset mid-hold: stack {S,W} with keycode=1A, pulse Reset for 1 cycle -> all outputs 0 immediately. With S and W still held -> keycode=8'h1A after DEB_FRAMES edges.

Source files
------------

// File: rtl/key_director.sv
// Direction-key front end: debounces the four WASD HID keycodes across frames and
// drives the most recently pressed key that is still held to the ball controller.
module key_director #(
    parameter int unsigned DEB_FRAMES = 2
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [47:0] keys_in,
    output logic [7:0]  keycode,
    output logic        dir_valid,
    output logic        dir_change
);

    typedef enum logic [1:0] {
        KEY_A = 2'd0,
        KEY_D = 2'd1,
        KEY_S = 2'd2,
        KEY_W = 2'd3
    } key_idx_e;

    function automatic logic [7:0] key_code(input logic [1:0] idx);
        case (key_idx_e'(idx))
            KEY_A:   key_code = 8'h04;
            KEY_D:   key_code = 8'h07;
            KEY_S:   key_code = 8'h16;
            default: key_code = 8'h1A;
        endcase
    endfunction

    logic [3:0]       raw;
    logic             rollover;
    logic [3:0]       raw_eff;
    logic [3:0]       db;
    logic [3:0]       db_prev;
    logic [3:0][2:0]  cnt;
    logic [3:0][1:0]  stack;
    logic [2:0]       depth;
    logic [3:0][1:0]  n_stack;
    logic [2:0]       n_depth;
    logic [7:0]       n_keycode;
    logic [3:0]       rose;
    logic [3:0]       fell;

    always_comb begin
        raw      = '0;
        rollover = 1'b0;
        for (int unsigned s = 0; s < 6; s++) begin
            if (keys_in[8*s +: 8] == 8'h01)
                rollover = 1'b1;
            for (int unsigned k = 0; k < 4; k++) begin
                if (keys_in[8*s +: 8] == key_code(k[1:0]))
                    raw[k] = 1'b1;
            end
        end
        // ErrorRollOver freezes the frame: pretend every key matches its debounced state
        raw_eff = rollover ? db : raw;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            db  <= '0;
            cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (raw_eff[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == 3'(DEB_FRAMES - 1)) begin
                    db[i]  <= raw_eff[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 3'd1;
                end
            end
        end
    end

    assign rose = db & ~db_prev;
    assign fell = ~db & db_prev;

    // Compact out released keys (order kept), then push new presses A..W so W lands on top.
    always_comb begin
        n_stack = '0;
        n_depth = '0;
        for (int unsigned e = 0; e < 4; e++) begin
            if ((3'(e) < depth) && !fell[stack[e]] && (n_depth < 3'd4)) begin
                n_stack[n_depth[1:0]] = stack[e];
                n_depth = n_depth + 3'd1;
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            if (rose[k] && (n_depth < 3'd4)) begin
                n_stack[n_depth[1:0]] = k[1:0];
                n_depth = n_depth + 3'd1;
            end
        end
        n_keycode = '0;
        if (n_depth != 3'd0)
            n_keycode = key_code(n_stack[2'(n_depth - 3'd1)]);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            db_prev    <= '0;
            stack      <= '0;
            depth      <= '0;
            keycode    <= '0;
            dir_valid  <= 1'b0;
            dir_change <= 1'b0;
        end else begin
            db_prev    <= db;
            stack      <= n_stack;
            depth      <= n_depth;
            keycode    <= n_keycode;
            dir_valid  <= (n_keycode != 8'h00);
            dir_change <= (n_keycode != keycode);
        end
    end

endmodule

// File: tb/tb_key_director.sv
// Bench for key_director: a queue-based press-order model checked every frame,
// plus directed scenarios with hand-computed keycode expectations.
module tb_key_director;

    localparam int unsigned DEB = 2;

    localparam logic [47:0] K_A0  = 48'h0000_0000_0004;
    localparam logic [47:0] K_D1  = 48'h0000_0000_0700;
    localparam logic [47:0] K_S0  = 48'h0000_0000_0016;
    localparam logic [47:0] K_W2  = 48'h0000_001A_0000;
    localparam logic [47:0] K_W1  = 48'h0000_0000_1A00;
    localparam logic [47:0] K_ROV = 48'h0100_0000_0000;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [47:0] keys_in;
    logic [7:0]  keycode;
    logic        dir_valid;
    logic        dir_change;

    int n_total = 0;
    int n_pass  = 0;

    key_director #(.DEB_FRAMES(DEB)) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keys_in    (keys_in),
        .keycode    (keycode),
        .dir_valid  (dir_valid),
        .dir_change (dir_change)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] code_of(input int idx);
        case (idx)
            0:       return 8'h04;
            1:       return 8'h07;
            2:       return 8'h16;
            default: return 8'h1A;
        endcase
    endfunction

    // Model: held-frames counting per key, and an ordered list of held keys.
    int         m_run[4];
    bit         m_db[4];
    bit         m_prev[4];
    int         m_order[$];
    logic [7:0] m_key   = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_chg   = 1'b0;

    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0; m_db[i] = 0; m_prev[i] = 0;
            end
            m_order.delete();
            m_key = 8'h00; m_valid = 1'b0; m_chg = 1'b0;
        end else begin
            bit   raw[4];
            bit   freeze;
            logic [7:0] nk;
            freeze = 0;
            for (int i = 0; i < 4; i++) raw[i] = 0;
            for (int s = 0; s < 6; s++) begin
                if (keys_in[8*s +: 8] == 8'h01) freeze = 1;
                for (int i = 0; i < 4; i++)
                    if (keys_in[8*s +: 8] == code_of(i)) raw[i] = 1;
            end
            for (int i = 0; i < 4; i++) begin
                if (m_prev[i] && !m_db[i]) begin
                    for (int j = 0; j < m_order.size(); j++)
                        if (m_order[j] == i) begin m_order.delete(j); break; end
                end
            end
            for (int i = 0; i < 4; i++)
                if (!m_prev[i] && m_db[i]) m_order.push_back(i);
            for (int i = 0; i < 4; i++) m_prev[i] = m_db[i];
            for (int i = 0; i < 4; i++) begin
                if (!freeze && raw[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin m_db[i] = raw[i]; m_run[i] = 0; end
                end else begin
                    m_run[i] = 0;
                end
            end
            nk = (m_order.size() > 0) ? code_of(m_order[$]) : 8'h00;
            m_chg   = (nk != m_key);
            m_key   = nk;
            m_valid = (nk != 8'h00);
        end
    end

    always @(negedge frame_clk) begin
        check("model_keycode", keycode, m_key);
        check("model_valid", {7'd0, dir_valid}, {7'd0, m_valid});
        check("model_change", {7'd0, dir_change}, {7'd0, m_chg});
    end

    task automatic frames(input logic [47:0] k, input int n);
        keys_in = k;
        repeat (n) @(negedge frame_clk);
    endtask

    initial begin
        Reset   = 1'b1;
        keys_in = K_A0;
        repeat (3) @(negedge frame_clk);
        check("reset_keycode", keycode, 8'h00);
        check("reset_valid", {7'd0, dir_valid}, 8'h00);
        check("reset_change", {7'd0, dir_change}, 8'h00);

        // Release reset with A held: keycode appears on the third edge after release
        Reset = 1'b0;
        frames(K_A0, 2);
        check("a_not_yet", keycode, 8'h00);
        frames(K_A0, 1);
        check("a_pressed", keycode, 8'h04);
        check("a_change_pulse", {7'd0, dir_change}, 8'h01);
        frames(K_A0, 1);
        check("a_change_single", {7'd0, dir_change}, 8'h00);

        // Priority: D over A, then back
        frames(K_A0 | K_D1, 3);
        check("prio_d", keycode, 8'h07);
        frames(K_A0, 2);
        check("prio_d_still", keycode, 8'h07);
        frames(K_A0, 1);
        check("prio_back_a", keycode, 8'h04);
        frames(48'h0, 3);
        check("prio_release", keycode, 8'h00);
        check("prio_release_valid", {7'd0, dir_valid}, 8'h00);

        // One-frame glitch on W
        frames(K_W2, 1);
        for (int i = 0; i < 4; i++) begin
            frames(48'h0, 1);
            check("glitch_key", keycode, 8'h00);
            check("glitch_change", {7'd0, dir_change}, 8'h00);
        end

        // Simultaneous A+W, then W release, add D, release A and D together
        frames(K_A0 | K_W2, 3);
        check("simul_w", keycode, 8'h1A);
        frames(K_A0, 3);
        check("simul_a", keycode, 8'h04);
        frames(K_A0 | K_D1, 3);
        check("simul_d", keycode, 8'h07);
        frames(48'h0, 2);
        check("dual_rel_hold", keycode, 8'h07);
        frames(48'h0, 1);
        check("dual_rel", keycode, 8'h00);
        check("dual_rel_change", {7'd0, dir_change}, 8'h01);

        // Rollover freeze with A removed
        frames(K_A0, 3);
        check("rov_a", keycode, 8'h04);
        for (int i = 0; i < 5; i++) begin
            frames(K_ROV, 1);
            check("rov_frozen", keycode, 8'h04);
        end
        frames(48'h0, 2);
        check("rov_after_hold", keycode, 8'h04);
        frames(48'h0, 1);
        check("rov_after", keycode, 8'h00);

        // Reset mid-hold with S and W held
        frames(K_S0 | K_W1, 3);
        check("sw_top", keycode, 8'h1A);
        #2 Reset = 1'b1;
        #1;
        check("midrst_key", keycode, 8'h00);
        check("midrst_valid", {7'd0, dir_valid}, 8'h00);
        check("midrst_change", {7'd0, dir_change}, 8'h00);
        @(negedge frame_clk);
        Reset = 1'b0;
        frames(K_S0 | K_W1, 2);
        check("midrst_redeb_hold", keycode, 8'h00);
        frames(K_S0 | K_W1, 1);
        check("midrst_redeb", keycode, 8'h1A);
        frames(K_S0, 3);
        check("midrst_s", keycode, 8'h16);
        frames(48'h0, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
